// File: rtl/varredura_display.sv
// Multiplexed 7-segment display scanner: one digit slot per DIV clocks, one-cycle
// dead time per slot, registered outputs. Define SUPRIME_ZEROS_EN for leading-zero blanking.
module varredura_display #(
    parameter TIPO  = "AC",
    parameter int N_DIG = 4,
    parameter int DIV   = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4*N_DIG-1:0]   entra,
    input  logic [N_DIG-1:0]     ponto,
    input  logic                 apaga,
    output logic [7:0]           sai,
    output logic [N_DIG-1:0]     dig
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    localparam logic IS_CC = (TIPO == "CC");
    localparam logic IS_AC = (TIPO == "AC");

    // Inactive levels: CC turns digits off with 1s, AC turns segments off with 1s.
    localparam logic [7:0]       SAI_OFF = IS_AC ? 8'hFF : 8'h00;
    localparam logic [N_DIG-1:0] DIG_OFF = {N_DIG{IS_CC}};

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       sai_d;
    logic [N_DIG-1:0] dig_d;

    // Active-high (common cathode) glyphs; bit0..bit6 = a..g.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    always_comb begin
        logic [7:0]       seg;
        logic [N_DIG-1:0] on;
`ifdef SUPRIME_ZEROS_EN
        logic             hi_zero;
`endif
        // NOTE: every output of this block gets a default first, so no path can
        // leave it unassigned and infer a latch.
        sai_d = 8'h00;
        dig_d = '0;
        seg   = {ponto[idx], decode(entra[idx*4 +: 4])};
`ifdef SUPRIME_ZEROS_EN
        hi_zero = 1'b1;
        for (int k = 0; k < N_DIG; k++) begin
            if (k >= int'(idx) && entra[4*k +: 4] != 4'h0)
                hi_zero = 1'b0;
        end
        // Digit 0 is never blanked so a zero value still reads "0"; dp stays live.
        if (hi_zero && idx != '0)
            seg[6:0] = 7'h00;
`endif
        if (apaga)
            seg = 8'h00;

        // Dead cycle at the start of every slot keeps the previous digit from ghosting.
        on = '0;
        if (N_DIG > 1 && cnt != '0)
            on[idx] = 1'b1;

        if (IS_CC) begin
            sai_d = seg;
            dig_d = ~on;
        end else if (IS_AC) begin
            sai_d = ~seg;
            dig_d = on;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
            sai <= SAI_OFF;
            dig <= DIG_OFF;
        end else begin
            // NOTE: non-blocking assignments so every register here samples the
            // pre-edge values of cnt and idx, giving the one-cycle output latency.
            sai <= sai_d;
            dig <= dig_d;
            if (cnt == CNT_W'(DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(N_DIG - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_varredura_display.sv
// Self-checking bench for varredura_display: CC/AC/invalid 4-digit instances and a
// 3-digit CC instance, compared every cycle against an arithmetic scan model.
module tb_varredura_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] entra;
    logic [3:0]  ponto;
    logic        apaga;

    logic [7:0] sai_cc, sai_ac, sai_xx, sai_c3;
    logic [3:0] dig_cc, dig_ac, dig_xx;
    logic [2:0] dig_c3;

    int tests_run = 0;
    int failures  = 0;
    int n = 0;  // output-register updates since reset release

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    varredura_display #(.TIPO("CC"), .N_DIG(4), .DIV(4)) u_cc (
        .clk(clk), .reset(reset), .entra(entra), .ponto(ponto), .apaga(apaga),
        .sai(sai_cc), .dig(dig_cc));
    varredura_display #(.TIPO("AC"), .N_DIG(4), .DIV(4)) u_ac (
        .clk(clk), .reset(reset), .entra(entra), .ponto(ponto), .apaga(apaga),
        .sai(sai_ac), .dig(dig_ac));
    varredura_display #(.TIPO("XX"), .N_DIG(4), .DIV(4)) u_xx (
        .clk(clk), .reset(reset), .entra(entra), .ponto(ponto), .apaga(apaga),
        .sai(sai_xx), .dig(dig_xx));
    varredura_display #(.TIPO("CC"), .N_DIG(3), .DIV(3)) u_c3 (
        .clk(clk), .reset(reset), .entra(entra[11:0]), .ponto(ponto[2:0]), .apaga(apaga),
        .sai(sai_c3), .dig(dig_c3));

    // Output n shows slot (n / div) mod ndig at position n mod div within that slot.
    // tipo: 0 = CC, 1 = AC, other = invalid. Returns {sai, dig zero-extended to 8 bits}.
    function automatic logic [15:0] model(input int tipo, input int ndig, input int div,
                                          input int cyc, input logic [31:0] e,
                                          input logic [7:0] p, input logic a);
        int          c, i;
        logic [31:0] hi;
        logic [7:0]  seg, on, mask, s, d;
        c   = cyc % div;
        i   = (cyc / div) % ndig;
        hi  = e >> (4 * i);
        seg = {p[i], glyph[hi[3:0]]};
`ifdef SUPRIME_ZEROS_EN
        if (i > 0 && hi == 32'h0) seg[6:0] = 7'h00;
`endif
        if (a) seg = 8'h00;
        on   = (ndig > 1 && c != 0) ? (8'd1 << i) : 8'd0;
        mask = (8'd1 << ndig) - 8'd1;
        case (tipo)
            0:       begin s = seg;  d = ~on & mask; end
            1:       begin s = ~seg; d = on;         end
            default: begin s = 8'h00; d = 8'h00;     end
        endcase
        return {s, d};
    endfunction

    // Computes expected outputs from the inputs present before the edge, clocks once,
    // then compares all four instances.
    task automatic scan_step(input string tag);
        logic [15:0] exp_v [4];
        logic [15:0] act_v [4];
        string       nm    [4];
        exp_v[0] = model(0, 4, 4, n, {16'h0, entra}, {4'h0, ponto}, apaga);
        exp_v[1] = model(1, 4, 4, n, {16'h0, entra}, {4'h0, ponto}, apaga);
        exp_v[2] = model(2, 4, 4, n, {16'h0, entra}, {4'h0, ponto}, apaga);
        exp_v[3] = model(0, 3, 3, n, {20'h0, entra[11:0]}, {5'h0, ponto[2:0]}, apaga);
        @(posedge clk);
        #1;
        act_v[0] = {sai_cc, 4'h0, dig_cc};
        act_v[1] = {sai_ac, 4'h0, dig_ac};
        act_v[2] = {sai_xx, 4'h0, dig_xx};
        act_v[3] = {sai_c3, 5'h0, dig_c3};
        nm[0] = "cc"; nm[1] = "ac"; nm[2] = "xx"; nm[3] = "cc3";
        for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (act_v[j] !== exp_v[j]) begin
                failures++;
                $display("FAIL %s/%s n=%0d: sai=%h dig=%b, expected sai=%h dig=%b",
                         tag, nm[j], n, act_v[j][15:8], act_v[j][7:0],
                         exp_v[j][15:8], exp_v[j][7:0]);
            end
        end
        n++;
    endtask

    task automatic check_inactive(input string tag);
        tests_run++;
        if ({sai_cc, dig_cc, sai_ac, dig_ac, sai_xx, dig_xx, sai_c3, dig_c3} !==
            {8'h00, 4'hF, 8'hFF, 4'h0, 8'h00, 4'h0, 8'h00, 3'h7}) begin
            failures++;
            $display("FAIL %s: cc=%h/%b ac=%h/%b xx=%h/%b cc3=%h/%b, expected inactive levels",
                     tag, sai_cc, dig_cc, sai_ac, dig_ac, sai_xx, dig_xx, sai_c3, dig_c3);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        n = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        entra = 16'h12AF;
        ponto = 4'h0;
        apaga = 1'b0;
        repeat (3) @(negedge clk);
        check_inactive("reset_hold");
        release_reset();
    endtask

    task automatic test_scan();
        for (int k = 0; k < 40; k++) begin
            scan_step("scan");
            if (k == 0) begin
                tests_run++;
                if (sai_cc !== 8'h71 || dig_cc !== 4'b1111) begin
                    failures++;
                    $display("FAIL scan_first_dead: sai=%h dig=%b, expected sai=71 dig=1111",
                             sai_cc, dig_cc);
                end
            end
            if (k == 1) begin
                tests_run++;
                if (sai_ac !== 8'h8E || dig_ac !== 4'b0001) begin
                    failures++;
                    $display("FAIL scan_ac_digit0: sai=%h dig=%b, expected sai=8E dig=0001",
                             sai_ac, dig_ac);
                end
            end
            if (k == 13) begin
                tests_run++;
                if (sai_cc !== 8'h06 || dig_cc !== 4'b0111) begin
                    failures++;
                    $display("FAIL scan_cc_digit3: sai=%h dig=%b, expected sai=06 dig=0111",
                             sai_cc, dig_cc);
                end
            end
        end
    endtask

    // Slot 2 spans outputs 8..11 in each 16-output frame; blank two mid-slot cycles.
    task automatic test_dp_apaga();
        ponto = 4'b0100;
        while (n % 16 != 8) scan_step("dp_align");
        scan_step("dp");                    // dead cycle of slot 2
        apaga = 1'b1;
        scan_step("apaga");
        scan_step("apaga");
        apaga = 1'b0;
        scan_step("dp");
        tests_run++;
        if (sai_cc !== 8'hDB || dig_cc !== 4'b1011) begin
            failures++;
            $display("FAIL dp_after_apaga: sai=%h dig=%b, expected sai=DB dig=1011",
                     sai_cc, dig_cc);
        end
        repeat (20) scan_step("dp");
        ponto = 4'h0;
    endtask

    task automatic test_mid_reset();
        while (n % 16 != 10) scan_step("mr_align");
        #3;
        reset = 1'b1;
        #1;
        check_inactive("reset_async");
        release_reset();
        scan_step("after_reset");
        tests_run++;
        if (dig_cc !== 4'b1111 || sai_cc !== 8'h71) begin
            failures++;
            $display("FAIL restart_slot0: sai=%h dig=%b, expected sai=71 dig=1111",
                     sai_cc, dig_cc);
        end
        repeat (20) scan_step("after_reset");
    endtask

    task automatic test_zero_blank();
        entra = 16'h0050;
        repeat (32) scan_step("lz_0050");
        entra = 16'h0000;
        repeat (32) scan_step("lz_0000");
        entra = 16'h0300;
        ponto = 4'b1010;
        repeat (32) scan_step("lz_0300");
        ponto = 4'h0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            entra = 16'($urandom);
            if ($urandom_range(3) == 0) entra[15:8] = 8'h00;
            ponto = 4'($urandom);
            apaga = ($urandom_range(7) == 0);
            scan_step("random");
        end
        apaga = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_dp_apaga();
        test_mid_reset();
        test_zero_blank();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/varredura_display.md
VARREDURA_DISPLAY -- requirements
Module: varredura_display

Interface
REQ-001 SHALL have parameter TIPO, default "AC", meaning display type: "AC" common anode, "CC" common cathode.
REQ-002 SHALL have parameter N_DIG, default 4, meaning number of multiplexed digits; legal range 1..8.
REQ-003 SHALL have parameter DIV, default 50000, meaning clock cycles per digit slot; legal range >= 2.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, meaning asynchronous, active-high reset.
REQ-006 SHALL have port entra, input, 4*N_DIG bits, meaning hex nibbles; nibble k = entra[4k+3:4k], and digit 0 is least significant.
REQ-007 SHALL have port ponto, input, N_DIG bits, meaning decimal-point request per digit; 1 = lit.
REQ-008 SHALL have port apaga, input, 1 bit, meaning blank all segments while high.
REQ-009 SHALL have port sai, output, 8 bits, meaning segments; bit0..bit6 = a..g, bit7 = dp.
REQ-010 SHALL have port dig, output, N_DIG bits, meaning digit enables; bit k drives digit k.

Function
REQ-011 SHALL keep a divisor counter cnt that counts 0..DIV-1, wraps to 0, and is ceil(log2(DIV)) bits wide.
REQ-012 SHALL keep a slot index idx that advances on the edge where cnt wraps, and wraps from N_DIG-1 to 0.
REQ-013 SHALL register sai and dig, each computed from the pre-edge values of cnt, idx, entra, ponto and apaga, giving 1-cycle latency.
REQ-014 SHALL make dig fully inactive when cnt==0 (one-cycle dead time per slot, anti-ghosting); in all other cycles only bit idx of dig is active.
REQ-015 SHALL decode nibbles 0-F with standard glyphs; CC active-high patterns are 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-016 SHALL set sai[7] active when ponto[idx]=1.
REQ-017 SHALL use polarity for TIPO "CC": sai active-high, dig active-low.
REQ-018 SHALL use polarity for TIPO "AC": sai active-low (bitwise inverse of CC), dig active-high.
REQ-019 SHALL drive sai=8'h00 and dig=0 every cycle, with counters still running, when TIPO is any other value.
REQ-020 SHALL make sai, including dp, inactive when apaga=1, with dig scanning unchanged, effective on the next output register update.
REQ-021 SHALL show input changes mid-slot on sai one cycle later, with no per-slot snapshot.
REQ-022 SHALL never assert dig when N_DIG=1, as in REQ-014.

Reset
REQ-023 SHALL clear cnt=0 and idx=0 while reset=1, asynchronously and independent of clk.
REQ-024 SHALL hold outputs at inactive level while reset=1: CC sai=8'h00, dig=all 1; AC sai=8'hFF, dig=all 0; invalid TIPO both 0.
REQ-025 SHALL start a reset asserted mid-slot with the first slot (idx=0, cnt=0) after release.

Configuration
REQ-026 SHALL, with macro SUPRIME_ZEROS_EN defined, apply leading-zero blanking: segments a..g inactive for digit k when nibble k and every higher nibble are 0, with k>0.
REQ-027 SHALL never blank digit 0 under leading-zero blanking, so value 0 shows "0".
REQ-028 SHALL keep dp controlled by ponto for digits blanked as leading zeros.
REQ-029 SHALL, without SUPRIME_ZEROS_EN, show every digit, including leading zeros.

Verification
REQ-030 SHALL cover: CC, N_DIG=4, DIV=4, entra=16'h12AF, ponto=0, reset released -> per slot 1 dead cycle (dig=4'b1111) then 3 cycles each of dig=1110/sai=71, dig=1101/sai=77, dig=1011/sai=5B, dig=0111/sai=06, repeating.
REQ-031 SHALL cover: same config with TIPO="AC" -> sai=8E,88,A4,F9, dig=0001,0010,0100,1000, dead cycles dig=0000.
REQ-032 SHALL cover: ponto=4'b0100, apaga pulsed high for 2 cycles inside digit 2's slot -> dp bit7 set only in digit 2's slot; sai inactive for exactly the 2 cycles one clock later; dig unaffected.
REQ-033 SHALL cover: reset asserted mid-slot 2 and released -> outputs inactive immediately, before any clk edge; idx restarts at 0 with a dead cycle.
REQ-034 SHALL cover: SUPRIME_ZEROS_EN defined, entra=16'h0050 -> digits 3,2 sai=00, digit 1=6D, digit 0=3F; entra=0 -> only digit 0 shows 3F; undefined -> digits 3,2 show 3F.
REQ-035 SHALL cover: TIPO="XX" -> sai=00 and dig=0 for 100 cycles after reset.
